// File: rtl/vga_timing_gen_pkg.sv
// vga_pkg: shared types, default 640x480@60 timing and axis helpers
// for the vga_timing_gen raster timing generator.
package vga_pkg;

   localparam int DEF_CW        = 10;

   localparam int DEF_H_ACTIVE  = 640;
   localparam int DEF_H_FP      = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BP      = 48;

   localparam int DEF_V_ACTIVE  = 480;
   localparam int DEF_V_FP      = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BP      = 33;

   localparam bit DEF_HSYNC_POL = 1'b0;
   localparam bit DEF_VSYNC_POL = 1'b0;
   localparam int DEF_CLK_DIV   = 1;

   typedef logic [DEF_CW-1:0] coord_t;

   function automatic int axis_total(
      input int active,
      input int fp,
      input int sync,
      input int bp
   );
      return active + fp + sync + bp;
   endfunction

   function automatic int sync_start(
      input int active,
      input int fp
   );
      return active + fp;
   endfunction

   function automatic int sync_end(
      input int active,
      input int fp,
      input int sync
   );
      return active + fp + sync;
   endfunction

   function automatic int div_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

   localparam int DEF_H_TOTAL =
      axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int DEF_V_TOTAL =
      axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: run control and raster outputs of vga_timing_gen.
// With VGA_LINE_MATCH_EN it also carries match_line / line_match.
interface vga_timing_gen_if
   import vga_pkg::*;
#(
   parameter int CW = DEF_CW
);
   logic          run;
   logic          hsync;
   logic          vsync;
   logic          sync_b;
   logic          blank_b;
   logic [CW-1:0] vgaX;
   logic [CW-1:0] vgaY;
   logic          pix_en;
   logic          line_start;
   logic          frame_start;
`ifdef VGA_LINE_MATCH_EN
   logic [CW-1:0] match_line;
   logic          line_match;

   modport master (
      input  run, match_line,
      output hsync, vsync, sync_b, blank_b,
      output vgaX, vgaY, pix_en,
      output line_start, frame_start, line_match
   );

   modport slave (
      output run, match_line,
      input  hsync, vsync, sync_b, blank_b,
      input  vgaX, vgaY, pix_en,
      input  line_start, frame_start, line_match
   );
`else
   modport master (
      input  run,
      output hsync, vsync, sync_b, blank_b,
      output vgaX, vgaY, pix_en,
      output line_start, frame_start
   );

   modport slave (
      output run,
      input  hsync, vsync, sync_b, blank_b,
      input  vgaX, vgaY, pix_en,
      input  line_start, frame_start
   );
`endif
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// vga_axis_counter: one raster axis (position, sync window, active area).
// Used once for pixels within a line and once for lines within a frame.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE = DEF_H_ACTIVE,
   parameter int FP     = DEF_H_FP,
   parameter int SYNC   = DEF_H_SYNC,
   parameter int BP     = DEF_H_BP,
   parameter bit POL    = 1'b0,
   parameter int CW     = DEF_CW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          adv,
   output logic [CW-1:0] count,
   output logic          sync,
   output logic          active,
   output logic          wrap
);

   localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

   localparam logic [CW:0] LAST = (CW+1)'(TOTAL - 1);
   localparam logic [CW:0] S_LO = (CW+1)'(sync_start(ACTIVE, FP));
   localparam logic [CW:0] S_HI = (CW+1)'(sync_end(ACTIVE, FP, SYNC));
   localparam logic [CW:0] ACT  = (CW+1)'(ACTIVE);

   logic [CW-1:0] count_d;
   logic [CW-1:0] count_q;
   logic [CW:0]   count_x;
   logic          sync_d;
   logic          sync_q;

   assign wrap = adv & ({1'b0, count_q} == LAST);

   // next position: idle clears, otherwise step and wrap on adv
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (wrap) begin
         count_d = '0;
      end else if (adv) begin
         count_d = count_q + 1'b1;
      end
   end

   // sync decoded from the next position so it lines up with count
   always_comb begin
      count_x = {1'b0, count_d};
      sync_d  = ~POL;
      if ((count_x >= S_LO) && (count_x < S_HI)) begin
         sync_d = POL;
      end
   end

   // position and sync registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
         sync_q  <= ~POL;
      end else begin
         count_q <= count_d;
         sync_q  <= sync_d;
      end
   end

   assign count  = count_q;
   assign sync   = sync_q;
   assign active = ({1'b0, count_q} < ACT);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel-enable divider.
// Optional macro VGA_LINE_MATCH_EN adds the match_line/line_match compare.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE  = DEF_H_ACTIVE,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_ACTIVE  = DEF_V_ACTIVE,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP,
   parameter bit HSYNC_POL = DEF_HSYNC_POL,
   parameter bit VSYNC_POL = DEF_VSYNC_POL,
   parameter int CLK_DIV   = DEF_CLK_DIV,
   parameter int CW        = DEF_CW
) (
   input  logic             clk,
   input  logic             reset,
   vga_timing_gen_if.master vga
);

   localparam int DW = div_width(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic          go;
   logic [DW-1:0] div_d;
   logic [DW-1:0] div_q;
   logic          pix_en;
   logic          h_wrap;
   logic          unused_v_wrap;
   logic          h_sync;
   logic          v_sync;
   logic          h_active;
   logic          v_active;
   logic          line_start;
   logic [CW-1:0] x;
   logic [CW-1:0] y;

   // a held reset behaves as idle so strobes stay low meanwhile
   assign go     = vga.run & reset;
   assign pix_en = go & (div_q == DIV_LAST);

   // divider phase, restarted from zero whenever scanning stops
   always_comb begin
      div_d = div_q;
      if (!go) begin
         div_d = '0;
      end else if (div_q == DIV_LAST) begin
         div_d = '0;
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   // divider register
   always_ff @(posedge clk) begin
      if (!reset) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .POL    (HSYNC_POL),
      .CW     (CW)
   ) u_h (
      .clk    (clk),
      .reset  (reset),
      .clr    (~go),
      .adv    (pix_en),
      .count  (x),
      .sync   (h_sync),
      .active (h_active),
      .wrap   (h_wrap)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .POL    (VSYNC_POL),
      .CW     (CW)
   ) u_v (
      .clk    (clk),
      .reset  (reset),
      .clr    (~go),
      .adv    (h_wrap),
      .count  (y),
      .sync   (v_sync),
      .active (v_active),
      .wrap   (unused_v_wrap)
   );

   assign line_start = pix_en & (x == '0);

   assign vga.vgaX        = x;
   assign vga.vgaY        = y;
   assign vga.hsync       = h_sync;
   assign vga.vsync       = v_sync;
   assign vga.sync_b      = ~((h_sync == HSYNC_POL) |
                              (v_sync == VSYNC_POL));
   assign vga.blank_b     = go & h_active & v_active;
   assign vga.pix_en      = pix_en;
   assign vga.line_start  = line_start;
   assign vga.frame_start = line_start & (y == '0);

`ifdef VGA_LINE_MATCH_EN
   assign vga.line_match  = line_start & (y == vga.match_line);
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three generators (small 1:1, small /3 high-true,
// default 640x480) checked every cycle against an arithmetic raster model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

   localparam int SHA = 16;
   localparam int SHF = 2;
   localparam int SHS = 3;
   localparam int SHB = 4;
   localparam int SVA = 6;
   localparam int SVF = 1;
   localparam int SVS = 2;
   localparam int SVB = 2;

   typedef struct {
      int x;
      int y;
      bit hs;
      bit vs;
      bit bl;
      bit pe;
      bit ls;
      bit fs;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   n0 = 0;
   int   n1 = 0;
   int   n2 = 0;
   bit   mvalid = 1'b0;
   exp_t e0, e1, e2;

   always #5 clk = ~clk;

   vga_timing_gen_if #(.CW(6))  if0 ();
   vga_timing_gen_if #(.CW(6))  if1 ();
   vga_timing_gen_if #(.CW(10)) if2 ();

   vga_timing_gen #(
      .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(1), .CW(6)
   ) u0 (.clk(clk), .reset(reset), .vga(if0));

   vga_timing_gen #(
      .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(3), .CW(6)
   ) u1 (.clk(clk), .reset(reset), .vga(if1));

   vga_timing_gen u2 (.clk(clk), .reset(reset), .vga(if2));

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, want);
      end
   endtask

   // n = clk edges scanned since the last idle/reset edge
   function automatic exp_t model(
      input int n, input bit go,
      input int ha, input int hf, input int hsw, input int hb,
      input int va, input int vf, input int vsw, input int vb,
      input int d
   );
      exp_t e;
      int ht, vt, p;
      ht   = ha + hf + hsw + hb;
      vt   = va + vf + vsw + vb;
      p    = (n / d) % (ht * vt);
      e.x  = p % ht;
      e.y  = p / ht;
      e.hs = (e.x >= ha + hf) && (e.x < ha + hf + hsw);
      e.vs = (e.y >= va + vf) && (e.y < va + vf + vsw);
      e.pe = go && ((n % d) == d - 1);
      e.bl = go && (e.x < ha) && (e.y < va);
      e.ls = e.pe && (e.x == 0);
      e.fs = e.ls && (e.y == 0);
      return e;
   endfunction

   task automatic cmp(
      input string t, input exp_t e, input bit hp, input bit vp,
      input logic [31:0] x, input logic [31:0] y,
      input logic hs, input logic vs, input logic sb, input logic bb,
      input logic pe, input logic ls, input logic fs
   );
      chk({t, ".vgaX"}, x, e.x);
      chk({t, ".vgaY"}, y, e.y);
      chk({t, ".hsync"}, hs, e.hs ? hp : !hp);
      chk({t, ".vsync"}, vs, e.vs ? vp : !vp);
      chk({t, ".sync_b"}, sb, !(e.hs || e.vs));
      chk({t, ".blank_b"}, bb, e.bl);
      chk({t, ".pix_en"}, pe, e.pe);
      chk({t, ".line_start"}, ls, e.ls);
      chk({t, ".frame_start"}, fs, e.fs);
   endtask

   always @(posedge clk) begin
      if (!reset) mvalid <= 1'b1;
      n0 <= (!reset || !if0.run) ? 0 : n0 + 1;
      n1 <= (!reset || !if1.run) ? 0 : n1 + 1;
      n2 <= (!reset || !if2.run) ? 0 : n2 + 1;
   end

   always @(negedge clk) begin
      #2;
      if (mvalid) begin
         e0 = model(n0, if0.run & reset, SHA, SHF, SHS, SHB,
                    SVA, SVF, SVS, SVB, 1);
         e1 = model(n1, if1.run & reset, SHA, SHF, SHS, SHB,
                    SVA, SVF, SVS, SVB, 3);
         e2 = model(n2, if2.run & reset, 640, 16, 96, 48,
                    480, 10, 2, 33, 1);
         cmp("u0", e0, 1'b0, 1'b0, if0.vgaX, if0.vgaY, if0.hsync,
             if0.vsync, if0.sync_b, if0.blank_b, if0.pix_en,
             if0.line_start, if0.frame_start);
         cmp("u1", e1, 1'b1, 1'b1, if1.vgaX, if1.vgaY, if1.hsync,
             if1.vsync, if1.sync_b, if1.blank_b, if1.pix_en,
             if1.line_start, if1.frame_start);
         cmp("u2", e2, 1'b0, 1'b0, if2.vgaX, if2.vgaY, if2.hsync,
             if2.vsync, if2.sync_b, if2.blank_b, if2.pix_en,
             if2.line_start, if2.frame_start);
`ifdef VGA_LINE_MATCH_EN
         chk("u0.line_match", if0.line_match,
             e0.ls && (e0.y == int'(if0.match_line)));
`endif
      end
   end

   initial begin
      if0.run = 1'b1;
      if1.run = 1'b0;
      if2.run = 1'b1;
`ifdef VGA_LINE_MATCH_EN
      if0.match_line = 6'd5;
      if1.match_line = '0;
      if2.match_line = '0;
`endif
      reset = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst.u0.pix_en", if0.pix_en, 0);
      chk("rst.u0.frame_start", if0.frame_start, 0);
      chk("rst.u1.hsync", if1.hsync, 0);
      chk("rst.u1.vsync", if1.vsync, 0);
      chk("rst.u1.sync_b", if1.sync_b, 1);
      chk("rst.u2.vgaX", if2.vgaX, 0);
      @(negedge clk);
      reset = 1'b1;

      fork
         begin
            automatic int cyc = 0, bl = 0, hlo = 0, hwin = 0;
            automatic int vlo = 0, lm = 0;
            #1;
            chk("u0.fs_at_release", if0.frame_start, 1);
            do begin
               cyc++;
               if (if0.blank_b) bl++;
               if (!if0.hsync) begin
                  hlo++;
                  if (if0.vgaX >= 18 && if0.vgaX <= 20) hwin++;
               end
               if (!if0.vsync) vlo++;
`ifdef VGA_LINE_MATCH_EN
               if (if0.line_match) lm++;
`endif
               @(negedge clk);
               #1;
            end while (!if0.frame_start && cyc < 1000);
            chk("u0.frame_period", cyc, 275);
            chk("u0.blank_count", bl, 96);
            chk("u0.hsync_low", hlo, 33);
            chk("u0.hsync_window", hwin, 33);
            chk("u0.vsync_low", vlo, 50);
`ifdef VGA_LINE_MATCH_EN
            chk("u0.line_match_count", lm, 1);
`endif
         end
         begin
            automatic int k = 0, per = 0;
            repeat (4) @(negedge clk);
            if1.run = 1'b1;
            #1;
            while (!if1.frame_start && k < 20) begin
               @(negedge clk);
               #1;
               k++;
            end
            chk("u1.first_fs_delay", k, 2);
            do begin
               @(negedge clk);
               #1;
               per++;
            end while (!if1.frame_start && per < 3000);
            chk("u1.frame_period", per, 825);
         end
         begin
            automatic int k = 0, w = 0;
            #1;
            while (if2.hsync && k < 2000) begin
               @(negedge clk);
               #1;
               k++;
            end
            chk("u2.hsync_start_x", if2.vgaX, 656);
            while (!if2.hsync && w < 2000) begin
               @(negedge clk);
               #1;
               w++;
            end
            chk("u2.hsync_width", w, 96);
         end
      join

      begin
         automatic int k = 0;
         @(negedge clk);
         while (!(if0.vgaX == 10 && if0.vgaY == 3) && k < 400) begin
            @(negedge clk);
            k++;
         end
         chk("u0.reach_10_3", k < 400, 1);
         chk("u0.pre_drop.blank_b", if0.blank_b, 1);
         if0.run = 1'b0;
         #1;
         chk("u0.drop.blank_b", if0.blank_b, 0);
         chk("u0.drop.pix_en", if0.pix_en, 0);
         @(negedge clk);
         #1;
         chk("u0.idle.vgaX", if0.vgaX, 0);
         chk("u0.idle.vgaY", if0.vgaY, 0);
         chk("u0.idle.hsync", if0.hsync, 1);
         chk("u0.idle.vsync", if0.vsync, 1);
         chk("u0.idle.blank_b", if0.blank_b, 0);
         @(negedge clk);
         if0.run = 1'b1;
         #1;
         chk("u0.restart.frame_start", if0.frame_start, 1);

         k = 0;
         @(negedge clk);
         while (!(if0.vgaX == 20 && if0.vgaY == 4) && k < 400) begin
            @(negedge clk);
            k++;
         end
         chk("u0.reach_20_4", k < 400, 1);
         chk("u0.pre_rst.hsync", if0.hsync, 0);
         reset = 1'b0;
         @(negedge clk);
         #1;
         chk("mrst.u0.vgaX", if0.vgaX, 0);
         chk("mrst.u0.vgaY", if0.vgaY, 0);
         chk("mrst.u0.hsync", if0.hsync, 1);
         chk("mrst.u0.vsync", if0.vsync, 1);
         chk("mrst.u0.sync_b", if0.sync_b, 1);
         chk("mrst.u0.blank_b", if0.blank_b, 0);
         chk("mrst.u0.pix_en", if0.pix_en, 0);
         chk("mrst.u0.line_start", if0.line_start, 0);
         chk("mrst.u0.frame_start", if0.frame_start, 0);
         chk("mrst.u1.hsync", if1.hsync, 0);
         chk("mrst.u1.sync_b", if1.sync_b, 1);
         @(negedge clk);
         reset = 1'b1;
      end

      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 149) == 0) if0.run = ~if0.run;
         if ($urandom_range(0, 149) == 0) if1.run = ~if1.run;
         if ($urandom_range(0, 399) == 0) if2.run = ~if2.run;
         reset = ($urandom_range(0, 799) != 0);
`ifdef VGA_LINE_MATCH_EN
         if ($urandom_range(0, 299) == 0)
            if0.match_line = 6'($urandom_range(0, 15));
`endif
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, the next generation of the fixed 640x480 controller behind the top-level `vga` wrapper. It runs from one system clock with an internal pixel-enable divider, so no dedicated pixel-clock PLL is needed. Its porch/sync widths and sync polarities are set by parameters, and it adds a run/idle control plus line and frame strobes. It feeds pixel coordinates to the pixel store and sync/blank signals to the monitor and DAC.

## Interface
- H_ACTIVE, 640, visible pixels per line; H_FP, 16; H_SYNC, 96; H_BP, 48 (pixels)
- V_ACTIVE, 480, visible lines; V_FP, 10; V_SYNC, 2; V_BP, 33 (lines)
- HSYNC_POL, 0, asserted level of hsync; VSYNC_POL, 0, asserted level of vsync
- CLK_DIV, 1, clk cycles per pixel (>=1)
- CW, 10, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- clk  input  1  system clock
- reset  input  1  synchronous, active-low
- run  input  1  1 = scan; 0 = hold idle at (0,0)
- hsync, vsync  output  1  sync pulses, polarity per *_POL
- sync_b  output  1  composite sync, low while either sync is asserted
- blank_b  output  1  high in the visible region only
- vgaX, vgaY  output  CW  current pixel coordinate
- pix_en  output  1  pixel-advance strobe
- line_start  output  1  one-clk pulse at the first pixel of each line
- frame_start  output  1  one-clk pulse at pixel (0,0)

## Operation
- H_TOTAL = sum of the four H_* parameters (800 at defaults); V_TOTAL likewise (525).
- Divider counter div runs 0..CLK_DIV-1 and wraps. pix_en is combinational: run & (div==CLK_DIV-1). With CLK_DIV=1, pix_en equals run.
- On pix_en, vgaX increments. At H_TOTAL-1 it wraps to 0 and vgaY increments. vgaY wraps to 0 after V_TOTAL-1.
- hsync is asserted while H_ACTIVE+H_FP <= vgaX < H_ACTIVE+H_FP+H_SYNC. vsync is asserted on the equivalent window in vgaY.
- blank_b = run & (vgaX<H_ACTIVE) & (vgaY<V_ACTIVE).
- sync_b = ~(hsync asserted | vsync asserted).
- line_start = pix_en & (vgaX==0). frame_start = line_start & (vgaY==0).
- Idle behaviour (run=0):
  - div, vgaX and vgaY are cleared to 0 on the next edge.
  - Syncs are deasserted and blank_b is 0.
- Mid-frame run fall: the block is idle on the next edge, with no frame completion.
- Run rise: scanning restarts at (0,0). The first frame_start coincides with the first pix_en, CLK_DIV-1 cycles after run is sampled high.

## Timing
- Outputs valid after reset: vgaX=vgaY=0, div=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, sync_b=1, blank_b=0, pix_en=0, line_start=0, frame_start=0.
- Reset has priority over run.
- vgaX, vgaY, div and both sync registers are flopped. Sync registers are computed from next-state counts, so they align with vgaX/vgaY in the same cycle.
- blank_b, sync_b and the strobes are combinational from registers. There is zero latency between coordinate and sync/blank.
- Simultaneous H and V wrap at (H_TOTAL-1, V_TOTAL-1) yields (0,0) on one edge.
- Period: one frame = H_TOTAL*V_TOTAL*CLK_DIV clk cycles, exact.

## Configuration
- Macro: `VGA_LINE_MATCH_EN`.
- Defined:
  - Adds input `match_line` (CW) and output `line_match` (1).
  - line_match is a one-clk pulse equal to line_start & (vgaY==match_line).
  - match_line is sampled every cycle; no pulse fires if it is >= V_TOTAL.
  - Reset value of line_match is 0.
- Undefined: neither port exists and behaviour is otherwise identical.

## Structure
- Package `vga_pkg`:
  - Typedef `coord_t` (logic [CW-1:0] at default CW).
  - Localparam helpers computing H_TOTAL/V_TOTAL and the sync window bounds.
  - Default 640x480@60 timing constants.
- Sub-module `vga_axis_counter`, instantiated twice (horizontal and vertical):
  - Parameters: ACTIVE, FP, SYNC, BP, POL.
  - Inputs: clk, reset, clr, adv.
  - Outputs: count, sync, active, wrap.
  - Horizontal `wrap` drives vertical `adv`.

## Test plan
- Defaults, CLK_DIV=1, run=1 from reset:
  - hsync low for exactly 96 cycles, starting at vgaX=656.
  - Line period 800 cycles; frame_start period 420000 cycles.
  - vsync low on vgaY 490..491; blank_b high for exactly 640x480 cycles per frame.
- CLK_DIV=4:
  - pix_en once every 4 clk; vgaX holds for 4 cycles.
  - First frame_start 3 cycles after run rises; frame period 1680000.
- HSYNC_POL=1, VSYNC_POL=1: sync pulses are high-true. At reset, hsync=vsync=0 and sync_b=1.
- run dropped at (300,200):
  - Next edge gives (0,0) with blank_b=0 and syncs deasserted.
  - Raising run restarts at (0,0) with a frame_start pulse.
- reset asserted mid-line at (700,100): all outputs take their reset values on the next edge, regardless of run.
- With `VGA_LINE_MATCH_EN`, match_line=479: exactly one line_match pulse per frame, at vgaX=0, vgaY=479. With match_line=600 there is no pulse.
